control_sequencer: RTL



---
 rtl/cpu_pkg.sv | 18 +
 rtl/control_sequencer_op_decode.sv | 13 +
 rtl/control_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, sequencer state and opcode-class enums shared by the control unit.
package cpu_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT} state_e;
  typedef enum logic [2:0] {C_BINARY, C_UNARY, C_NOP, C_HALT, C_ILLEGAL} op_class_e;
endpackage

// File: rtl/control_sequencer_op_decode.sv
// op_decode: classifies the 5-bit IR opcode into binary, unary, nop, halt or illegal.
module op_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output op_class_e  op_class_o
);
  always_comb
    op_class_o = (opcode_i inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL}) ? C_BINARY :
                 (opcode_i inside {OP_NEG, OP_NOT}) ? C_UNARY :
                 (opcode_i == OP_NOP) ? C_NOP :
                 (opcode_i == OP_HALT) ? C_HALT : C_ILLEGAL;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control FSM with fetch timeout fault.
// Defining SEQ_STEP_EN adds a Step input; each Step pulse admits one instruction.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
`ifdef SEQ_STEP_EN
  input  logic        Step,
`endif
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  ALU_op,
  output logic        Run,
  output logic        Fault
);
  localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);
  state_e     state_q;
  logic [7:0] cnt_q;
  logic       fault_q;
  op_class_e  op_class;
  logic       adv;
  state_e     resume;
  logic       bin, un, ex_alu;
  logic       unused_ir;
  assign unused_ir = ^IR[26:0];
  op_decode u_dec (.opcode_i(IR[31:27]), .op_class_o(op_class));
`ifdef SEQ_STEP_EN
  assign adv = Step;
`else
  assign adv = 1'b1;
`endif
  // Without a step pulse the return to T0 parks in IDLE, which doubles as the stall state.
  assign resume = adv ? S_T0 : S_IDLE;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= resume;
        S_T0: begin
          state_q <= S_T1;
          cnt_q   <= '0;
        end
        S_T1:
          if (Mem_ready) state_q <= S_T2;
          else if (cnt_q == TO_LAST) begin
            state_q <= S_HALT;
            fault_q <= 1'b1;
          end else cnt_q <= cnt_q + 8'd1;
        S_T2: state_q <= S_T3;
        S_T3: begin
          state_q <= (op_class == C_BINARY || op_class == C_UNARY) ? S_T4 :
                     (op_class == C_HALT) ? S_HALT : resume;
          if (op_class == C_ILLEGAL) fault_q <= 1'b1;
        end
        S_T4: state_q <= (op_class == C_BINARY) ? S_T5 : resume;
        S_T5: state_q <= resume;
        default: state_q <= S_HALT;
      endcase
    end
  end
  assign bin    = op_class == C_BINARY;
  assign un     = op_class == C_UNARY;
  assign ex_alu = (state_q == S_T3 && un) || (state_q == S_T4 && bin);
  assign PCout   = state_q == S_T0;
  assign MARin   = state_q == S_T0;
  assign IncPC   = state_q == S_T0;
  assign Zin     = state_q == S_T0 || ex_alu;
  assign Zlowout = state_q == S_T1 || state_q == S_T5 || (state_q == S_T4 && un);
  assign PCin    = state_q == S_T1;
  assign Read    = state_q == S_T1;
  assign MDRin   = state_q == S_T1;
  assign MDRout  = state_q == S_T2;
  assign IRin    = state_q == S_T2;
  assign Grb     = state_q == S_T3 && (bin || un);
  assign Yin     = state_q == S_T3 && bin;
  assign Grc     = state_q == S_T4 && bin;
  assign Rout    = Grb || Grc;
  assign Gra     = state_q == S_T5 || (state_q == S_T4 && un);
  assign Rin     = Gra;
  assign ALU_op  = ex_alu ? IR[31:27] : 5'd0;
  assign Run     = state_q != S_HALT;
  assign Fault   = fault_q;
endmodule
